// File: rtl/bcd_stopwatch_mux_if.sv
// Stopwatch pin bundle: raw buttons in, display and status out.
`timescale 1ns/1ps
interface bcd_stopwatch_mux_if #(
  parameter int NDIGITS = 4
);
  logic                   btn_start;
  logic                   btn_stop;
  logic                   btn_clear;
  logic                   btn_lap;
  logic [6:0]             seg_n;
  logic                   dp_n;
  logic [NDIGITS-1:0]     dig_sel_n;
  logic [4*NDIGITS-1:0]   count_bcd;
  logic                   running;
  logic                   lap_hold;
  logic                   wrap;

  modport master (
    output btn_start, btn_stop, btn_clear, btn_lap,
    input  seg_n, dp_n, dig_sel_n, count_bcd,
    input  running, lap_hold, wrap
  );

  modport slave (
    input  btn_start, btn_stop, btn_clear, btn_lap,
    output seg_n, dp_n, dig_sel_n, count_bcd,
    output running, lap_hold, wrap
  );
endinterface

// File: rtl/bcd_stopwatch_mux.sv
// BCD stopwatch core: debounced buttons, run/stop/clear FSM,
// lap freeze and a multiplexed common-anode 7-segment scanner.
`timescale 1ns/1ps
module bcd_stopwatch_mux #(
  parameter int NDIGITS  = 4,
  parameter int TICK_DIV = 1200000,
  parameter int SCAN_DIV = 1024,
  parameter int DEB_CYC  = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_stopwatch_mux_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CYC);
  localparam int IW = $clog2(NDIGITS);
  localparam int CW = 4 * NDIGITS;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_e;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // button order: 0 start, 1 stop, 2 clear, 3 lap
  logic [3:0]         btn_raw;
  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0]         deb_q, deb_d;
  logic [3:0][DW-1:0] dcnt_q, dcnt_d;
  logic [3:0]         press_q, press_d;

  state_e             state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      lap_q, lap_d;
  logic               hold_q, hold_d;
  logic               wrap_q, wrap_d;

  logic [SW-1:0]      scnt_q, scnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [NDIGITS-1:0] dig_q, dig_d;

  logic               start_p, stop_p, clr_p, lap_p;
  logic               tick;
  logic               carry;
  logic               step;
  logic [CW-1:0]      src;

  assign btn_raw = {bus.btn_lap, bus.btn_clear,
                    bus.btn_stop, bus.btn_start};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    dcnt_d  = dcnt_q;
    press_d = '0;
    for (int b = 0; b < 4; b++) begin
      if (sync2_q[b] == deb_q[b]) begin
        dcnt_d[b] = '0;
      end else if (dcnt_q[b] == DEB_LAST) begin
        dcnt_d[b]  = '0;
        deb_d[b]   = sync2_q[b];
        press_d[b] = sync2_q[b];
      end else begin
        dcnt_d[b] = dcnt_q[b] + DW'(1);
      end
    end
  end

  assign start_p = press_q[0];
  assign stop_p  = press_q[1];
  assign clr_p   = press_q[2];
  assign lap_p   = press_q[3];

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      clr_p:   state_d = IDLE;
      stop_p:  if (state_q == RUN) state_d = STOP;
      start_p: if (state_q != RUN) state_d = RUN;
      default: state_d = state_q;
    endcase
  end

  assign tick = (state_q == RUN) && (tick_q == TICK_LAST);

  always_comb begin
    tick_d  = tick_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b0;
    if (clr_p || state_q == IDLE) begin
      tick_d = '0;
    end else if (state_q == RUN) begin
      tick_d = tick ? '0 : tick_q + TW'(1);
    end
    if (clr_p) begin
      count_d = '0;
    end else if (tick) begin
      carry = 1'b1;
      for (int k = 0; k < NDIGITS; k++) begin
        if (carry) begin
          if (count_q[4*k +: 4] == 4'd9) begin
            count_d[4*k +: 4] = 4'd0;
          end else begin
            count_d[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
      wrap_d = carry;
    end
  end

  always_comb begin
    lap_d  = lap_q;
    hold_d = hold_q;
    if (clr_p) begin
      hold_d = 1'b0;
    end else if (lap_p && state_q != IDLE) begin
      if (!hold_q) begin
        lap_d  = count_q;
        hold_d = 1'b1;
      end else begin
        hold_d = 1'b0;
      end
    end
  end

  // the scan pointer names the digit shown at the next step
  assign step = (scnt_q == SCAN_LAST);
  assign src  = hold_q ? lap_q : count_q;

  always_comb begin
    scnt_d = step ? '0 : scnt_q + SW'(1);
    idx_d  = idx_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    dig_d  = dig_q;
    if (step) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      dig_d = ~(NDIGITS'(1) << idx_q);
      seg_d = ~hex7(src[{idx_q, 2'b00} +: 4]);
      dp_d  = !(int'(idx_q) == 2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      dcnt_q  <= '0;
      press_q <= '0;
      state_q <= IDLE;
      tick_q  <= '0;
      count_q <= '0;
      lap_q   <= '0;
      hold_q  <= 1'b0;
      wrap_q  <= 1'b0;
      scnt_q  <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      dig_q   <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      press_q <= press_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      hold_q  <= hold_d;
      wrap_q  <= wrap_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.seg_n     = seg_q;
  assign bus.dp_n      = dp_q;
  assign bus.dig_sel_n = dig_q;
  assign bus.count_bcd = count_q;
  assign bus.running   = (state_q == RUN);
  assign bus.lap_hold  = hold_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_mux.sv
// Directed bench for bcd_stopwatch_mux with NDIGITS=3,
// TICK_DIV=4, SCAN_DIV=2, DEB_CYC=3.
`timescale 1ns/1ps
module tb_bcd_stopwatch_mux;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_stopwatch_mux_if #(.NDIGITS(3)) bus ();

  bcd_stopwatch_mux #(
    .NDIGITS (3),
    .TICK_DIV(4),
    .SCAN_DIV(2),
    .DEB_CYC (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       bus.btn_start = v;
      1:       bus.btn_stop  = v;
      2:       bus.btn_clear = v;
      default: bus.btn_lap   = v;
    endcase
  endtask

  task automatic press(input int b, input int n);
    set_btn(b, 1'b1);
    repeat (n) @(negedge clk);
    set_btn(b, 1'b0);
  endtask

  task automatic wait_count(input logic [11:0] v, input int lim,
                            input string tag);
    int n;
    n = 0;
    while (bus.count_bcd !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.count_bcd), 32'(v));
  endtask

  task automatic wait_dig(input logic [2:0] v, input int lim,
                          input string tag);
    int n;
    n = 0;
    while (bus.dig_sel_n !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.dig_sel_n), 32'(v));
  endtask

  logic [11:0] held;
  int          bad;

  initial begin
    rst_n = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    bus.btn_clear = 1'b0;
    bus.btn_lap   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg",   32'(bus.seg_n),     32'h7F);
    check("rst_dig",   32'(bus.dig_sel_n), 32'h7);
    check("rst_dp",    32'(bus.dp_n),      32'h1);
    check("rst_count", 32'(bus.count_bcd), 32'h0);
    check("rst_run",   32'(bus.running),   32'h0);
    check("rst_lap",   32'(bus.lap_hold),  32'h0);
    check("rst_wrap",  32'(bus.wrap),      32'h0);

    rst_n = 1'b1;
    check("rel_dig", 32'(bus.dig_sel_n), 32'h7);
    repeat (2) @(negedge clk);
    check("scan0_dig", 32'(bus.dig_sel_n), 32'h6);
    check("scan0_seg", 32'(bus.seg_n),     32'h40);
    check("scan0_dp",  32'(bus.dp_n),      32'h1);

    press(0, 8);
    check("start_run", 32'(bus.running), 32'h1);
    wait_count(12'h001, 12, "first_tick");
    repeat (4) @(negedge clk);
    check("tick2", 32'(bus.count_bcd), 32'h002);
    repeat (4) @(negedge clk);
    check("tick3", 32'(bus.count_bcd), 32'h003);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (bus.count_bcd[4*k +: 4] > 4'd9) bad++;
    end
    check("no_hex_digit", 32'(bad), 32'h0);
    check("tick13", 32'(bus.count_bcd), 32'h013);

    wait_count(12'h999, 5000, "reach_999");
    wait_count(12'h000, 8, "wrap_zero");
    check("wrap_hi",  32'(bus.wrap),    32'h1);
    check("wrap_run", 32'(bus.running), 32'h1);
    @(negedge clk);
    check("wrap_lo",  32'(bus.wrap),      32'h0);
    check("wrap_cnt", 32'(bus.count_bcd), 32'h000);

    press(1, 8);
    repeat (4) @(negedge clk);
    check("stop_run", 32'(bus.running), 32'h0);
    held = bus.count_bcd;
    repeat (12) @(negedge clk);
    check("stop_hold", 32'(bus.count_bcd), 32'(held));
    press(0, 2);
    repeat (12) @(negedge clk);
    check("glitch_run", 32'(bus.running),   32'h0);
    check("glitch_cnt", 32'(bus.count_bcd), 32'(held));
    press(0, 8);
    repeat (4) @(negedge clk);
    check("resume_run", 32'(bus.running), 32'h1);
    bus.btn_start = 1'b1;
    bus.btn_stop  = 1'b1;
    repeat (8) @(negedge clk);
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    repeat (4) @(negedge clk);
    check("both_stop", 32'(bus.running), 32'h0);

    press(2, 8);
    repeat (4) @(negedge clk);
    check("clr_count", 32'(bus.count_bcd), 32'h0);
    check("clr_run",   32'(bus.running),   32'h0);
    press(3, 8);
    repeat (4) @(negedge clk);
    check("idle_lap", 32'(bus.lap_hold), 32'h0);

    press(0, 8);
    wait_count(12'h024, 200, "reach_024");
    press(3, 8);
    repeat (12) @(negedge clk);
    check("lap_hold",  32'(bus.lap_hold),  32'h1);
    check("lap_live",  32'(bus.count_bcd), 32'h029);
    wait_dig(3'b110, 8, "lap_dig0");
    check("lap_seg0", 32'(bus.seg_n), 32'h12);
    repeat (2) @(negedge clk);
    check("lap_dig1", 32'(bus.dig_sel_n), 32'h5);
    check("lap_seg1", 32'(bus.seg_n),     32'h24);
    repeat (2) @(negedge clk);
    check("lap_dig2", 32'(bus.dig_sel_n), 32'h3);
    check("lap_seg2", 32'(bus.seg_n),     32'h40);
    check("lap_dp2",  32'(bus.dp_n),      32'h0);

    press(3, 8);
    repeat (4) @(negedge clk);
    check("lap_release", 32'(bus.lap_hold), 32'h0);
    press(3, 8);
    repeat (4) @(negedge clk);
    check("lap_again", 32'(bus.lap_hold), 32'h1);
    press(2, 8);
    repeat (4) @(negedge clk);
    check("clr2_run",   32'(bus.running),   32'h0);
    check("clr2_lap",   32'(bus.lap_hold),  32'h0);
    check("clr2_count", 32'(bus.count_bcd), 32'h0);

    press(0, 8);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(bus.seg_n),     32'h7F);
    check("arst_dig", 32'(bus.dig_sel_n), 32'h7);
    check("arst_dp",  32'(bus.dp_n),      32'h1);
    check("arst_run", 32'(bus.running),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
